pe_result_collector: RTL and testbench
======================================

Name: pe_result_collector

Overview:
- Downstream drain stage of the 1D FP16 systolic array.
- On a capture pulse, snapshots the PE_out values of all NUM_PE processing elements in parallel into shadow registers.
- Then serializes them, PE0 first, over a valid/ready stream to the writeback or host side.
- Shadowing frees the PE chain to start the next computation while results drain.

Parameters:
DATA_WIDTH, 16, width of one FP16 result word
NUM_PE, 4, number of processing elements in the chain (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset; 0 = reset asserted
pe_out_bus  input  NUM_PE*DATA_WIDTH  concatenated PE_out values; PE i at bits [i*DATA_WIDTH +: DATA_WIDTH]
capture  input  1  one-cycle strobe from array controller: results on pe_out_bus are final
out_ready  input  1  downstream can accept out_data this cycle
clr_overflow  input  1  synchronous clear of the sticky overflow flag
out_data  output  DATA_WIDTH  current result word
out_valid  output  1  out_data/out_index/out_last valid
out_index  output  IDX_W  PE index of out_data; IDX_W = max(1, $clog2(NUM_PE)) as a localparam
out_last  output  1  high with out_valid when out_index == NUM_PE-1
busy  output  1  high while in DRAIN
overflow  output  1  sticky: a capture was dropped

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE.
  - Shadow registers, out_data, out_index, out_valid, out_last, busy, overflow all 0.
  - Reset mid-drain aborts the drain; remaining words are lost.
- FSM states: IDLE, DRAIN.
- IDLE:
  - capture == 1 loads all NUM_PE words from pe_out_bus into shadow registers and sets index = 0.
  - Next state is DRAIN.
  - out_valid is first high in the cycle after the capture edge (1-cycle latency).
- DRAIN:
  - out_valid = 1, out_data = shadow[index].
  - A handshake is out_valid && out_ready sampled at the rising edge; on a handshake, index increments.
  - Without a handshake, out_data, out_index and out_last hold stable (AXI-stream-style stability rule).
  - Handshake at index == NUM_PE-1: next state is IDLE and out_valid drops the next cycle, unless capture is also 1 in that cycle.
  - Capture on the last handshake: reload the shadow registers, index = 0, stay in DRAIN. This gives gap-free back-to-back operation.
  - Capture in DRAIN on any other cycle: ignored, shadow registers untouched, overflow set to 1.
- overflow:
  - Sticky; cleared only by clr_overflow or reset.
  - If clr_overflow and a new dropped capture occur in the same cycle, set wins.
- Outputs:
  - busy equals (state == DRAIN).
  - out_last = out_valid && (index == NUM_PE-1).
- Data is passed bit-exact; no FP16 arithmetic in this block (see optional feature).
- Throughput: one word per cycle with out_ready held high. NUM_PE cycles per batch, plus 1 capture-to-valid cycle when starting from IDLE.

Optional Feature:
- Macro: RESULT_RELU_EN.
- Defined: each word is clamped at capture time. If the FP16 sign bit (bit DATA_WIDTH-1) is 1, the stored word is 16'h0000; otherwise it is stored unchanged. Negative NaNs and -0 also map to 0x0000.
- Undefined: words are stored and emitted bit-exact.
- The handshake and timing are identical in both builds.

Test Plan:
- Basic drain:
  - Stimulus: NUM_PE=4, pe_out_bus = {16'hce9a, 16'h4c33, 16'h4600, 16'h4000}, capture pulse, out_ready=1.
  - Required: out_data 4000, 4600, 4c33, ce9a on 4 consecutive cycles; out_index 0..3; out_last only on ce9a; busy then 0.
- Backpressure:
  - Stimulus: same data, out_ready low for 3 cycles while index = 1.
  - Required: out_data stays 16'h4600 and out_index stays 1 throughout; the sequence then completes unchanged.
- Overflow:
  - Stimulus: capture at index 1.
  - Required: the drain continues with the original data; overflow = 1 and stays 1 until a clr_overflow pulse returns it to 0.
- Back-to-back:
  - Stimulus: second capture with bus {16'h3c00 x4} on the same cycle as the last handshake.
  - Required: next cycle out_valid = 1, out_index = 0, out_data = 16'h3c00; overflow remains 0.
- Reset mid-drain:
  - Stimulus: reset driven 0 at index 2, asynchronously between edges.
  - Required: out_valid, busy and out_data are 0 immediately; after release, IDLE and no output until the next capture.
- RELU build:
  - Stimulus: RESULT_RELU_EN defined, basic drain data.
  - Required: outputs 4000, 4600, 4c33, 0000.

Source files
------------

// File: rtl/pe_result_collector.sv
// ---------------------------------------------------------------------------
// pe_result_collector
//
// Drain stage of the 1D FP16 systolic array. A capture strobe snapshots all
// NUM_PE PE_out words into shadow registers in one cycle. Those words are then
// streamed out, PE0 first, one word per handshake. The PE chain is free to
// start the next computation as soon as the snapshot is taken.
//
// Optional feature (compile-time macro RESULT_RELU_EN):
//   defined   : words whose sign bit is set are stored as zero at capture.
//   undefined : words are stored and emitted bit-exact.
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and no transfer happens,
// out_data, out_index and out_last stay stable. out_valid never depends on
// out_ready.
//
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   pe_out_bus   : NUM_PE words, PE i at [i*DATA_WIDTH +: DATA_WIDTH]
//   capture      : one-cycle strobe, pe_out_bus holds final results
//   out_ready    : downstream accepts the current word
//   clr_overflow : synchronous clear of the sticky overflow flag
//   out_data     : current result word (0 when not valid)
//   out_valid    : out_data / out_index / out_last are valid
//   out_index    : PE index of out_data (0 when not valid)
//   out_last     : valid word is from PE NUM_PE-1
//   busy         : high while draining
//   overflow     : sticky, a capture arrived mid-drain and was dropped
//   state_dbg    : current FSM state (0 = IDLE, 1 = DRAIN)
// ---------------------------------------------------------------------------
module pe_result_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 4,
  localparam int IDX_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_out_bus,
  input  logic                         capture,
  input  logic                         out_ready,
  input  logic                         clr_overflow,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic [IDX_W-1:0]             out_index,
  output logic                         out_last,
  output logic                         busy,
  output logic                         overflow,
  output logic                         state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   shadow [NUM_PE];
  logic [IDX_W-1:0]        idx;
  logic                    hs;
  logic                    at_last;
  logic                    load;
  logic                    drop;

  // Clamp applied while loading the shadow registers.
  function automatic logic [DATA_WIDTH-1:0] store_word(input logic [DATA_WIDTH-1:0] w);
`ifdef RESULT_RELU_EN
    return w[DATA_WIDTH-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign hs      = (state == DRAIN) && out_ready;
  assign at_last = (idx == LAST_IDX);
  // A capture is accepted when idle, or when it coincides with the final
  // handshake so the next batch follows without a bubble.
  assign load    = capture && ((state == IDLE) || (hs && at_last));
  assign drop    = capture && (state == DRAIN) && !(hs && at_last);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = DRAIN;
      DRAIN:   if (hs && at_last && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow registers, drain index and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) shadow[i] <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        for (int i = 0; i < NUM_PE; i++)
          shadow[i] <= store_word(pe_out_bus[i*DATA_WIDTH +: DATA_WIDTH]);
        idx <= '0;
      end else if (hs) begin
        idx <= at_last ? '0 : idx + IDX_W'(1);
      end
      // A dropped capture outranks a simultaneous clear.
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Outputs, all derived from registered state
  always_comb begin
    out_valid = (state == DRAIN);
    busy      = (state == DRAIN);
    state_dbg = state;
    out_data  = out_valid ? shadow[idx] : '0;
    out_index = out_valid ? idx : '0;
    out_last  = out_valid && at_last;
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// ---------------------------------------------------------------------------
// tb_pe_result_collector
//
// Bench for pe_result_collector (DATA_WIDTH=16, NUM_PE=4). Directed vector
// table, a reset-mid-drain sequence, then random traffic against a queue
// model of the drain behaviour. Inputs change 1 time unit after the rising
// edge; outputs are read at that same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_pe_result_collector;

  localparam int DW    = 16;
  localparam int NPE   = 4;
  localparam int IDX_W = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NPE*DW-1:0] pe_out_bus = '0;
  logic              capture = 1'b0;
  logic              out_ready = 1'b0;
  logic              clr_overflow = 1'b0;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;
  logic              busy;
  logic              overflow;
  logic              state_dbg;

  pe_result_collector #(.DATA_WIDTH(DW), .NUM_PE(NPE)) dut (
    .clk          (clk),
    .reset        (reset),
    .pe_out_bus   (pe_out_bus),
    .capture      (capture),
    .out_ready    (out_ready),
    .clr_overflow (clr_overflow),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [NPE*DW-1:0] BUS_B = {16'hce9a, 16'h4c33, 16'h4600, 16'h4000};
  localparam logic [NPE*DW-1:0] BUS_R = {16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00};
`ifdef RESULT_RELU_EN
  localparam logic [DW-1:0] NEG_W = 16'h0000;
`else
  localparam logic [DW-1:0] NEG_W = 16'hce9a;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic cap, input logic rdy, input logic clr,
                       input logic [NPE*DW-1:0] bus);
    capture = cap; out_ready = rdy; clr_overflow = clr; pe_out_bus = bus;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [IDX_W-1:0] ix, input logic l,
                          input logic b, input logic ov);
    chk({tag, ".valid"},    32'(out_valid), 32'(v));
    chk({tag, ".data"},     32'(out_data),  32'(d));
    chk({tag, ".index"},    32'(out_index), 32'(ix));
    chk({tag, ".last"},     32'(out_last),  32'(l));
    chk({tag, ".busy"},     32'(busy),      32'(b));
    chk({tag, ".overflow"}, 32'(overflow),  32'(ov));
  endtask

  // Reference model: queue of words still to be delivered.
  logic [DW-1:0] exp_q[$];
  logic          mdl_ov;

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] w);
`ifdef RESULT_RELU_EN
    if (w[DW-1]) return '0;
`endif
    return w;
  endfunction

  task automatic model_step(input logic cap, input logic rdy, input logic clr,
                            input logic [NPE*DW-1:0] bus);
    bit was_busy, fin;
    was_busy = (exp_q.size() > 0);
    fin      = was_busy && rdy && (exp_q.size() == 1);
    if (was_busy && rdy) void'(exp_q.pop_front());
    if (cap && (!was_busy || fin)) begin
      for (int i = 0; i < NPE; i++) exp_q.push_back(clamp(bus[i*DW +: DW]));
      if (clr) mdl_ov = 1'b0;
    end else if (cap) begin
      mdl_ov = 1'b1;
    end else if (clr) begin
      mdl_ov = 1'b0;
    end
  endtask

  typedef struct {
    logic              cap;
    logic              rdy;
    logic              clr;
    logic [NPE*DW-1:0] bus;
    logic              v;
    logic [DW-1:0]     d;
    logic [IDX_W-1:0]  ix;
    logic              l;
    logic              ov;
  } vec_t;

  vec_t vecs[30];

  task automatic setv(input int n, input logic cap, input logic rdy, input logic clr,
                      input logic [NPE*DW-1:0] bus, input logic v, input logic [DW-1:0] d,
                      input logic [IDX_W-1:0] ix, input logic l, input logic ov);
    vecs[n].cap = cap; vecs[n].rdy = rdy; vecs[n].clr = clr; vecs[n].bus = bus;
    vecs[n].v = v; vecs[n].d = d; vecs[n].ix = ix; vecs[n].l = l; vecs[n].ov = ov;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // basic drain with backpressure at index 1
    setv(0,  1,1,0,BUS_B, 1,16'h4000,0,0,0);
    setv(1,  0,1,0,BUS_B, 1,16'h4600,1,0,0);
    setv(2,  0,0,0,BUS_B, 1,16'h4600,1,0,0);
    setv(3,  0,0,0,BUS_B, 1,16'h4600,1,0,0);
    setv(4,  0,0,0,BUS_B, 1,16'h4600,1,0,0);
    setv(5,  0,1,0,BUS_B, 1,16'h4c33,2,0,0);
    setv(6,  0,1,0,BUS_B, 1,NEG_W,   3,1,0);
    setv(7,  0,1,0,BUS_B, 0,16'h0000,0,0,0);
    // overflow: capture dropped at index 1, then cleared
    setv(8,  1,1,0,BUS_B, 1,16'h4000,0,0,0);
    setv(9,  0,1,0,BUS_B, 1,16'h4600,1,0,0);
    setv(10, 1,0,0,BUS_R, 1,16'h4600,1,0,1);
    setv(11, 0,1,0,BUS_R, 1,16'h4c33,2,0,1);
    setv(12, 0,1,0,BUS_R, 1,NEG_W,   3,1,1);
    setv(13, 0,1,1,BUS_R, 0,16'h0000,0,0,0);
    // back-to-back: capture on last handshake
    setv(14, 1,1,0,BUS_B, 1,16'h4000,0,0,0);
    setv(15, 0,1,0,BUS_B, 1,16'h4600,1,0,0);
    setv(16, 0,1,0,BUS_B, 1,16'h4c33,2,0,0);
    setv(17, 0,1,0,BUS_B, 1,NEG_W,   3,1,0);
    setv(18, 1,1,0,BUS_R, 1,16'h3c00,0,0,0);
    setv(19, 0,1,0,BUS_B, 1,16'h3c00,1,0,0);
    setv(20, 0,1,0,BUS_B, 1,16'h3c00,2,0,0);
    setv(21, 0,1,0,BUS_B, 1,16'h3c00,3,1,0);
    setv(22, 0,1,0,BUS_B, 0,16'h0000,0,0,0);
    // drop and clear in the same cycle: set wins
    setv(23, 1,0,0,BUS_B, 1,16'h4000,0,0,0);
    setv(24, 1,0,1,BUS_R, 1,16'h4000,0,0,1);
    setv(25, 0,0,1,BUS_R, 1,16'h4000,0,0,0);
    setv(26, 0,1,0,BUS_R, 1,16'h4600,1,0,0);
    setv(27, 0,1,0,BUS_R, 1,16'h4c33,2,0,0);
    setv(28, 0,1,0,BUS_R, 1,NEG_W,   3,1,0);
    setv(29, 0,1,0,BUS_R, 0,16'h0000,0,0,0);

    // reset state
    drive(0, 0, 0, '0);
    tick(); tick();
    chk_outs("reset", 0, 16'h0000, 0, 0, 0, 0);
    chk("reset.state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    tick();
    chk_outs("post_reset", 0, 16'h0000, 0, 0, 0, 0);

    // directed vector table
    foreach (vecs[n]) begin
      drive(vecs[n].cap, vecs[n].rdy, vecs[n].clr, vecs[n].bus);
      tick();
      chk_outs($sformatf("vec%0d", n), vecs[n].v, vecs[n].d, vecs[n].ix, vecs[n].l,
               vecs[n].v, vecs[n].ov);
    end

    // reset asserted asynchronously in the middle of a drain at index 2
    drive(1, 1, 0, BUS_B); tick();
    drive(0, 1, 0, BUS_B); tick(); tick();
    chk("mid.index_before", 32'(out_index), 32'd2);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst.valid", 32'(out_valid), 32'd0);
    chk("mid_rst.busy",  32'(busy),      32'd0);
    chk("mid_rst.data",  32'(out_data),  32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_outs($sformatf("after_rst%0d", k), 0, 16'h0000, 0, 0, 0, 0);
    end
    drive(1, 0, 0, BUS_R); tick();
    chk_outs("after_rst_cap", 1, 16'h3c00, 0, 0, 1, 0);

    // random traffic against the model, starting from a fresh reset
    drive(0, 0, 0, '0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    mdl_ov = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic              cap, rdy, clr;
      logic [NPE*DW-1:0] bus;
      logic              v;
      cap = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 9) == 0);
      bus = {$urandom(), $urandom()};
      drive(cap, rdy, clr, bus);
      model_step(cap, rdy, clr, bus);
      tick();
      v = (exp_q.size() > 0);
      chk_outs($sformatf("rnd%0d", c), v, v ? exp_q[0] : 16'h0000,
               v ? IDX_W'(NPE - exp_q.size()) : IDX_W'(0),
               exp_q.size() == 1, v, mdl_ov);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
